// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_rx serial deserializer.
// Holds the FSM state encoding and the bit-counter width helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    OUT_VALID,
    BOTH_FULL
  } sipo_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/sipo_rx.sv
// Double-buffered LSB-first serial-to-parallel receiver.
// Define SIPO_RX_PARITY_EN to add a trailing even-parity bit per frame.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             serial_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] parallel_o,
  output logic             pvalid_o,
  input  logic             pready_i,
  output logic             parity_err_o
);

`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = cnt_w(WIDTH);

  sipo_state_e      r_state;
  sipo_state_e      w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_word;
  logic             w_acc;
  logic             w_last;
  logic             w_load;
  logic             w_park;
  logic             w_unpark;

  assign ready_o    = ~reset & (r_state != BOTH_FULL);
  assign pvalid_o   = (r_state != EMPTY);
  assign parallel_o = r_out;
  assign w_acc      = valid_i & ready_o;
  assign w_last     = w_acc & (r_cnt == CW'(FRAME - 1));

  // Current word with the incoming data bit merged in place.
  always_comb begin
    w_word = r_shift;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_acc && (r_cnt == CW'(i))) w_word[i] = serial_i;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_load   = 1'b0;
    w_park   = 1'b0;
    w_unpark = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_last) begin
          w_nxt  = OUT_VALID;
          w_load = 1'b1;
        end
      end
      OUT_VALID: begin
        if (w_last && pready_i) begin
          w_load = 1'b1;
        end else if (w_last) begin
          w_nxt  = BOTH_FULL;
          w_park = 1'b1;
        end else if (pready_i) begin
          w_nxt = EMPTY;
        end
      end
      BOTH_FULL: begin
        if (pready_i) begin
          w_nxt    = OUT_VALID;
          w_unpark = 1'b1;
        end
      end
      default: w_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_out   <= '0;
    end else begin
      if (w_acc) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      // A parked word stays in the shift register until unparked.
      if (w_load || w_unpark) r_shift <= '0;
      else if (w_acc)         r_shift <= w_word;
      if (w_load)        r_out <= w_word;
      else if (w_unpark) r_out <= r_shift;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  logic r_sp;
  logic r_pp;
  logic r_perr;
  logic w_perr;

  assign w_perr       = r_sp ^ serial_i;
  assign parity_err_o = r_perr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp   <= 1'b0;
      r_pp   <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (w_last)     r_sp <= 1'b0;
      else if (w_acc) r_sp <= w_perr;
      if (w_park)     r_pp <= w_perr;
      if (w_load)        r_perr <= w_perr;
      else if (w_unpark) r_perr <= r_pp;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: directed scenarios plus random traffic
// compared against a word-queue reference model.
module tb_sipo_rx;

  localparam int W = 4;
`ifdef SIPO_RX_PARITY_EN
  localparam int FRAME = W + 1;
  localparam bit PEN = 1'b1;
`else
  localparam int FRAME = W;
  localparam bit PEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_i = 1'b0;
  logic         serial_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] parallel_o;
  logic         pvalid_o;
  logic         pready_i = 1'b0;
  logic         parity_err_o;

  int tests = 0;
  int fails = 0;

  // Model: queue of completed words {perr, data}; front is the output.
  logic [W:0]   mq[$];
  logic [W-1:0] m_pw;
  logic         m_par;
  int           m_cnt;

  sipo_rx #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (valid_i),
    .serial_i    (serial_i),
    .ready_o     (ready_o),
    .parallel_o  (parallel_o),
    .pvalid_o    (pvalid_o),
    .pready_i    (pready_i),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_pw  = '0;
    m_par = 1'b0;
    m_cnt = 0;
  endtask

  // One clock: entered and left just after a falling edge.
  task automatic cyc(input logic v, input logic s, input logic pr);
    logic acc;
    logic pop;
    valid_i  = v;
    serial_i = s;
    pready_i = pr;
    #1;
    chk("ready", 32'(ready_o), 32'(mq.size() < 2));
    chk("pvalid", 32'(pvalid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("data", 32'(parallel_o), 32'(mq[0][W-1:0]));
      chk("perr", 32'(parity_err_o), 32'(mq[0][W]));
    end
    acc = v && (mq.size() < 2);
    pop = pr && (mq.size() > 0);
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      if (m_cnt < W) m_pw[m_cnt] = s;
      m_par = m_par ^ s;
      m_cnt++;
      if (m_cnt == FRAME) begin
        mq.push_back({m_par & PEN, m_pw});
        m_pw  = '0;
        m_par = 1'b0;
        m_cnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    valid_i = 1'b0;
    #1;
    chk("rst_ready_lo", 32'(ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_pvalid", 32'(pvalid_o), 32'd0);
    chk("rst_data", 32'(parallel_o), 32'd0);
    chk("rst_perr", 32'(parity_err_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    reset = 1'b0;
    model_clear();
  endtask

  // Send n frame bits LSB first; prlast is pready_i on the final bit.
  task automatic send_raw(input logic [W:0] f, input int n, input int gap,
                          input logic pr, input logic prlast);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, f[i], (i == n - 1) ? prlast : pr);
      if (i != n - 1)
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, pr);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap,
                           input logic pr, input logic prlast);
    send_raw({^w, w}, FRAME, gap, pr, prlast);
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    do_reset();

    send_word(4'b1101, 0, 1'b1, 1'b1);
    chk("basic_data", 32'(parallel_o), 32'hD);
    chk("basic_pvalid", 32'(pvalid_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("basic_pvalid_lo", 32'(pvalid_o), 32'd0);

    send_word(4'b1101, 2, 1'b1, 1'b1);
    chk("gap_data", 32'(parallel_o), 32'hD);
    cyc(1'b0, 1'b0, 1'b1);

    send_word(4'hA, 0, 1'b0, 1'b0);
    send_word(4'h5, 0, 1'b0, 1'b0);
    chk("bp_ready_lo", 32'(ready_o), 32'd0);
    chk("bp_hold", 32'(parallel_o), 32'hA);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("bp_hold2", 32'(parallel_o), 32'hA);
    cyc(1'b0, 1'b0, 1'b1);
    chk("bp_unpark", 32'(parallel_o), 32'h5);
    chk("bp_ready_hi", 32'(ready_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);

    send_word(4'h3, 0, 1'b1, 1'b1);
    send_word(4'hC, 0, 1'b0, 1'b1);
    chk("sim_pvalid", 32'(pvalid_o), 32'd1);
    chk("sim_data", 32'(parallel_o), 32'hC);
    cyc(1'b0, 1'b0, 1'b1);

    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    do_reset();
    send_word(4'b0110, 0, 1'b1, 1'b1);
    chk("rst_mid_data", 32'(parallel_o), 32'h6);
    cyc(1'b0, 1'b0, 1'b1);

`ifdef SIPO_RX_PARITY_EN
    send_raw(5'b0_0011, 5, 0, 1'b1, 1'b1);
    chk("par_ok_data", 32'(parallel_o), 32'h3);
    chk("par_ok_err", 32'(parity_err_o), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    send_raw(5'b1_0011, 5, 0, 1'b1, 1'b1);
    chk("par_bad_err", 32'(parity_err_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0);
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 5) != 0, 1'($urandom), ($urandom % 4) != 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
